// File: rtl/breakout_pkg.sv
// breakout_pkg: shared state encoding, default parameters and helpers for the breakout controller.
// Revision 1.0
`default_nettype none

package breakout_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_LOST  = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   localparam logic [9:0] DEF_PADDLE_INIT  = 10'd480;
   localparam logic [9:0] DEF_PADDLE_MIN   = 10'd16;
   localparam logic [9:0] DEF_PADDLE_MAX   = 10'd944;
   localparam int         DEF_PADDLE_STEP  = 4;
   localparam int         DEF_START_LIVES  = 3;
   localparam int         DEF_SERVE_FRAMES = 60;
   localparam logic [7:0] DEF_TOTAL_BRICKS = 8'd32;

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? 8'hFF : value + 8'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/breakout_paddle_ctrl.sv
// breakout_paddle_ctrl: per-frame paddle motion with saturation at both screen limits.
// Revision 1.0
`default_nettype none

module breakout_paddle_ctrl
   import breakout_pkg::*;
#(
   parameter logic [9:0] PADDLE_INIT = DEF_PADDLE_INIT,
   parameter logic [9:0] PADDLE_MIN  = DEF_PADDLE_MIN,
   parameter logic [9:0] PADDLE_MAX  = DEF_PADDLE_MAX,
   parameter int         PADDLE_STEP = DEF_PADDLE_STEP
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       FrameTick,
   input  logic       enable,
   input  logic       LeftBtn,
   input  logic       RightBtn,
   input  logic       load,
   output logic [9:0] PaddleX
);

   localparam logic [10:0] c_STEP = 11'(PADDLE_STEP);
   localparam logic [10:0] c_MIN  = {1'b0, PADDLE_MIN};
   localparam logic [10:0] c_MAX  = {1'b0, PADDLE_MAX};

   logic [9:0]  r_paddle_x;
   logic [10:0] w_wide;
   logic [10:0] w_dec;
   logic [10:0] w_inc;
   logic [9:0]  w_next;

   assign w_wide = {1'b0, r_paddle_x};
   assign w_dec  = w_wide - c_STEP;
   assign w_inc  = w_wide + c_STEP;

   // Compare before subtracting so a small position never wraps through zero.
   always_comb begin
      w_next = r_paddle_x;
      if (LeftBtn && !RightBtn) begin
         w_next = (w_wide < c_MIN + c_STEP) ? PADDLE_MIN : w_dec[9:0];
      end else if (RightBtn && !LeftBtn) begin
         w_next = (w_inc > c_MAX) ? PADDLE_MAX : w_inc[9:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_paddle_x <= PADDLE_INIT;
      end else if (load) begin
         r_paddle_x <= PADDLE_INIT;
      end else if (enable && FrameTick) begin
         r_paddle_x <= w_next;
      end
   end

   assign PaddleX = r_paddle_x;

endmodule

`default_nettype wire

// File: rtl/breakout_game_ctrl.sv
// breakout_game_ctrl: game-flow FSM (serve, play, life loss, game over) with score and lives.
// Revision 1.0
`default_nettype none

module breakout_game_ctrl
   import breakout_pkg::*;
#(
   parameter logic [9:0] PADDLE_INIT  = DEF_PADDLE_INIT,
   parameter logic [9:0] PADDLE_MIN   = DEF_PADDLE_MIN,
   parameter logic [9:0] PADDLE_MAX   = DEF_PADDLE_MAX,
   parameter int         PADDLE_STEP  = DEF_PADDLE_STEP,
   parameter int         START_LIVES  = DEF_START_LIVES,
   parameter int         SERVE_FRAMES = DEF_SERVE_FRAMES,
   parameter logic [7:0] TOTAL_BRICKS = DEF_TOTAL_BRICKS
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       FrameTick,
   input  logic       StartBtn,
   input  logic       LeftBtn,
   input  logic       RightBtn,
   input  logic       Collision,
   input  logic       BrickHit,
   input  logic       BallLost,
   output logic [9:0] PaddleX,
   output logic       BallEnable,
   output logic       BallServe,
   output logic [7:0] Score,
   output logic [1:0] Lives,
   output logic       GameOver,
   output logic       Win
);

   localparam logic [1:0]  c_START_LIVES  = 2'(START_LIVES);
   localparam logic [15:0] c_SERVE_FRAMES = 16'(SERVE_FRAMES);

   state_t      r_state;
   logic        r_start_q;
   logic [15:0] r_frames;
   logic        r_brick_f;
   logic        r_lost_f;
   logic [7:0]  r_score;
   logic [1:0]  r_lives;
   logic        r_win;
   logic        r_ball_en;
   logic        r_ball_serve;
   logic        r_game_over;

   logic        w_start_rise;
   logic        w_brick_any;
   logic        w_lost_any;
   logic [7:0]  w_score_next;
   logic        w_paddle_load;
   logic        w_paddle_en;
   logic        w_unused;

   assign w_unused      = Collision;
   assign w_start_rise  = StartBtn && !r_start_q;
   assign w_brick_any   = r_brick_f || BrickHit;
   assign w_lost_any    = r_lost_f || BallLost;
   assign w_score_next  = w_brick_any ? sat_inc8(r_score) : r_score;
   // Paddle re-centres whenever a serve begins, and is pinned while idle.
   assign w_paddle_load = (r_state == ST_IDLE)
                        || ((r_state == ST_OVER) && w_start_rise)
                        || ((r_state == ST_LOST) && (r_lives != 2'd1));
   assign w_paddle_en   = (r_state == ST_SERVE) || (r_state == ST_PLAY);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_start_q    <= 1'b0;
         r_frames     <= '0;
         r_brick_f    <= 1'b0;
         r_lost_f     <= 1'b0;
         r_score      <= 8'd0;
         r_lives      <= c_START_LIVES;
         r_win        <= 1'b0;
         r_ball_en    <= 1'b0;
         r_ball_serve <= 1'b1;
         r_game_over  <= 1'b0;
      end else begin
         r_start_q    <= StartBtn;
         r_ball_en    <= (r_state == ST_PLAY);
         r_ball_serve <= (r_state != ST_PLAY);
         r_game_over  <= (r_state == ST_OVER);

         unique case (r_state)
            ST_IDLE, ST_OVER: begin
               if (w_start_rise) begin
                  r_score  <= 8'd0;
                  r_lives  <= c_START_LIVES;
                  r_win    <= 1'b0;
                  r_frames <= c_SERVE_FRAMES;
                  r_state  <= ST_SERVE;
               end
            end
            ST_SERVE: begin
               if (r_frames == 16'd0) begin
                  r_brick_f <= 1'b0;
                  r_lost_f  <= 1'b0;
                  r_state   <= ST_PLAY;
               end else if (FrameTick) begin
                  r_frames <= r_frames - 16'd1;
               end
            end
            ST_PLAY: begin
               if (FrameTick) begin
                  r_brick_f <= 1'b0;
                  r_lost_f  <= 1'b0;
                  r_score   <= w_score_next;
                  // Clearing the last brick wins even if the ball was lost this frame.
                  if (w_brick_any && (w_score_next == TOTAL_BRICKS)) begin
                     r_win   <= 1'b1;
                     r_state <= ST_OVER;
                  end else if (w_lost_any) begin
                     r_state <= ST_LOST;
                  end
               end else begin
                  r_brick_f <= w_brick_any;
                  r_lost_f  <= w_lost_any;
               end
            end
            ST_LOST: begin
               r_lives <= r_lives - 2'd1;
               if (r_lives == 2'd1) begin
                  r_win   <= 1'b0;
                  r_state <= ST_OVER;
               end else begin
                  r_frames <= c_SERVE_FRAMES;
                  r_state  <= ST_SERVE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   breakout_paddle_ctrl #(
      .PADDLE_INIT (PADDLE_INIT),
      .PADDLE_MIN  (PADDLE_MIN),
      .PADDLE_MAX  (PADDLE_MAX),
      .PADDLE_STEP (PADDLE_STEP)
   ) u_paddle (
      .clk       (clk),
      .reset     (reset),
      .FrameTick (FrameTick),
      .enable    (w_paddle_en),
      .LeftBtn   (LeftBtn),
      .RightBtn  (RightBtn),
      .load      (w_paddle_load),
      .PaddleX   (PaddleX)
   );

   assign BallEnable = r_ball_en;
   assign BallServe  = r_ball_serve;
   assign Score      = r_score;
   assign Lives      = r_lives;
   assign GameOver   = r_game_over;
   assign Win        = r_win;

endmodule

`default_nettype wire

// File: tb/tb_breakout_game_ctrl.sv
// tb_breakout_game_ctrl: directed scenarios for the breakout controller with hand-computed expectations.
// Revision 1.0
`default_nettype none

module tb_breakout_game_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       FrameTick = 1'b0;
   logic       StartBtn = 1'b0;
   logic       LeftBtn = 1'b0;
   logic       RightBtn = 1'b0;
   logic       Collision = 1'b0;
   logic       BrickHit = 1'b0;
   logic       BallLost = 1'b0;
   logic [9:0] PaddleX;
   logic       BallEnable;
   logic       BallServe;
   logic [7:0] Score;
   logic [1:0] Lives;
   logic       GameOver;
   logic       Win;

   int total = 0;
   int bad = 0;

   breakout_game_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .FrameTick  (FrameTick),
      .StartBtn   (StartBtn),
      .LeftBtn    (LeftBtn),
      .RightBtn   (RightBtn),
      .Collision  (Collision),
      .BrickHit   (BrickHit),
      .BallLost   (BallLost),
      .PaddleX    (PaddleX),
      .BallEnable (BallEnable),
      .BallServe  (BallServe),
      .Score      (Score),
      .Lives      (Lives),
      .GameOver   (GameOver),
      .Win        (Win)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic frame_tick();
      FrameTick = 1'b1;
      step(1);
      FrameTick = 1'b0;
   endtask

   task automatic start_pulse();
      StartBtn = 1'b1;
      step(1);
      StartBtn = 1'b0;
   endtask

   task automatic serve_to_play();
      for (int i = 0; i < 60; i++) begin
         frame_tick();
         step(1);
      end
      step(2);
   endtask

   task automatic lose_ball();
      BallLost = 1'b1;
      step(3);
      BallLost = 1'b0;
      step(2);
      frame_tick();
      step(3);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(3);
      reset = 1'b0;
      total++; if (PaddleX !== 10'd480) begin bad++; $display("FAIL reset_paddle: got %0d want 480", PaddleX); end
      total++; if (BallEnable !== 1'b0) begin bad++; $display("FAIL reset_enable: got %b want 0", BallEnable); end
      total++; if (BallServe !== 1'b1) begin bad++; $display("FAIL reset_serve: got %b want 1", BallServe); end
      total++; if (Score !== 8'd0) begin bad++; $display("FAIL reset_score: got %0d want 0", Score); end
      total++; if (Lives !== 2'd3) begin bad++; $display("FAIL reset_lives: got %0d want 3", Lives); end
      total++; if (GameOver !== 1'b0 || Win !== 1'b0) begin bad++; $display("FAIL reset_over_win: got %b%b want 00", GameOver, Win); end
      LeftBtn = 1'b1;
      for (int i = 0; i < 3; i++) begin frame_tick(); step(1); end
      LeftBtn = 1'b0;
      total++; if (PaddleX !== 10'd480) begin bad++; $display("FAIL idle_paddle_frozen: got %0d want 480", PaddleX); end
   endtask

   task automatic test_serve();
      StartBtn = 1'b1;
      step(5);
      StartBtn = 1'b0;
      step(2);
      total++; if (BallServe !== 1'b1 || BallEnable !== 1'b0) begin bad++; $display("FAIL serve_outputs: got serve=%b en=%b want 1 0", BallServe, BallEnable); end
      for (int i = 0; i < 59; i++) begin frame_tick(); step(1); end
      total++; if (BallEnable !== 1'b0) begin bad++; $display("FAIL serve_59_frames: got en=%b want 0", BallEnable); end
      frame_tick();
      total++; if (BallEnable !== 1'b0) begin bad++; $display("FAIL serve_tick60_edge: got en=%b want 0", BallEnable); end
      step(2);
      total++; if (BallEnable !== 1'b1 || BallServe !== 1'b0) begin bad++; $display("FAIL play_outputs: got en=%b serve=%b want 1 0", BallEnable, BallServe); end
      total++; if (Score !== 8'd0 || Lives !== 2'd3) begin bad++; $display("FAIL start_load: got score=%0d lives=%0d want 0 3", Score, Lives); end
   endtask

   task automatic test_brick_sticky();
      BrickHit = 1'b1;
      step(200);
      BrickHit = 1'b0;
      step(5);
      total++; if (Score !== 8'd0) begin bad++; $display("FAIL brick_before_tick: got %0d want 0", Score); end
      frame_tick();
      total++; if (Score !== 8'd1) begin bad++; $display("FAIL brick_at_tick: got %0d want 1", Score); end
      step(3);
      frame_tick();
      total++; if (Score !== 8'd1) begin bad++; $display("FAIL brick_cleared: got %0d want 1", Score); end
      Collision = 1'b1;
      step(10);
      Collision = 1'b0;
      total++; if (BallEnable !== 1'b1 || Score !== 8'd1) begin bad++; $display("FAIL collision_ignored: got en=%b score=%0d want 1 1", BallEnable, Score); end
   endtask

   task automatic test_paddle();
      LeftBtn = 1'b1;
      frame_tick();
      total++; if (PaddleX !== 10'd476) begin bad++; $display("FAIL paddle_left_one: got %0d want 476", PaddleX); end
      for (int i = 0; i < 199; i++) begin frame_tick(); step(1); end
      total++; if (PaddleX !== 10'd16) begin bad++; $display("FAIL paddle_left_sat: got %0d want 16", PaddleX); end
      LeftBtn = 1'b0;
      RightBtn = 1'b1;
      frame_tick();
      total++; if (PaddleX !== 10'd20) begin bad++; $display("FAIL paddle_right_one: got %0d want 20", PaddleX); end
      for (int i = 0; i < 249; i++) begin frame_tick(); step(1); end
      total++; if (PaddleX !== 10'd944) begin bad++; $display("FAIL paddle_right_sat: got %0d want 944", PaddleX); end
      LeftBtn = 1'b1;
      for (int i = 0; i < 5; i++) begin frame_tick(); step(1); end
      total++; if (PaddleX !== 10'd944) begin bad++; $display("FAIL paddle_both: got %0d want 944", PaddleX); end
      LeftBtn = 1'b0;
      RightBtn = 1'b0;
      step(8);
      total++; if (PaddleX !== 10'd944) begin bad++; $display("FAIL paddle_no_tick: got %0d want 944", PaddleX); end
   endtask

   task automatic test_lives();
      lose_ball();
      total++; if (Lives !== 2'd2) begin bad++; $display("FAIL lives_first: got %0d want 2", Lives); end
      total++; if (BallServe !== 1'b1 || BallEnable !== 1'b0) begin bad++; $display("FAIL lost_reserve: got serve=%b en=%b want 1 0", BallServe, BallEnable); end
      total++; if (PaddleX !== 10'd480) begin bad++; $display("FAIL lost_paddle_recentre: got %0d want 480", PaddleX); end
      serve_to_play();
      lose_ball();
      total++; if (Lives !== 2'd1 || GameOver !== 1'b0) begin bad++; $display("FAIL lives_second: got lives=%0d over=%b want 1 0", Lives, GameOver); end
      serve_to_play();
      lose_ball();
      total++; if (Lives !== 2'd0 || GameOver !== 1'b1 || Win !== 1'b0) begin bad++; $display("FAIL lives_third: got lives=%0d over=%b win=%b want 0 1 0", Lives, GameOver, Win); end
      BrickHit = 1'b1;
      for (int i = 0; i < 3; i++) begin frame_tick(); step(1); end
      BrickHit = 1'b0;
      total++; if (Score !== 8'd1 || BallServe !== 1'b1 || BallEnable !== 1'b0) begin bad++; $display("FAIL over_hold: got score=%0d serve=%b en=%b want 1 1 0", Score, BallServe, BallEnable); end
      start_pulse();
      step(2);
      total++; if (Lives !== 2'd3 || Score !== 8'd0 || GameOver !== 1'b0 || BallServe !== 1'b1) begin bad++; $display("FAIL over_restart: got lives=%0d score=%0d over=%b serve=%b want 3 0 0 1", Lives, Score, GameOver, BallServe); end
   endtask

   task automatic test_win();
      serve_to_play();
      for (int i = 0; i < 31; i++) begin
         BrickHit = 1'b1;
         step(1);
         BrickHit = 1'b0;
         frame_tick();
      end
      step(2);
      total++; if (Score !== 8'd31 || GameOver !== 1'b0) begin bad++; $display("FAIL score_31: got score=%0d over=%b want 31 0", Score, GameOver); end
      BrickHit = 1'b1;
      BallLost = 1'b1;
      step(2);
      BrickHit = 1'b0;
      BallLost = 1'b0;
      frame_tick();
      step(3);
      total++; if (Score !== 8'd32 || GameOver !== 1'b1 || Win !== 1'b1 || Lives !== 2'd3) begin bad++; $display("FAIL win_priority: got score=%0d over=%b win=%b lives=%0d want 32 1 1 3", Score, GameOver, Win, Lives); end
      start_pulse();
      step(2);
      total++; if (Win !== 1'b0 || GameOver !== 1'b0 || Score !== 8'd0) begin bad++; $display("FAIL win_restart: got win=%b over=%b score=%0d want 0 0 0", Win, GameOver, Score); end
   endtask

   task automatic test_reset_mid_serve();
      LeftBtn = 1'b1;
      for (int i = 0; i < 30; i++) begin frame_tick(); step(1); end
      total++; if (PaddleX !== 10'd360) begin bad++; $display("FAIL serve_paddle_move: got %0d want 360", PaddleX); end
      reset = 1'b1;
      FrameTick = 1'b1;
      StartBtn = 1'b1;
      step(1);
      FrameTick = 1'b0;
      StartBtn = 1'b0;
      reset = 1'b0;
      LeftBtn = 1'b0;
      total++; if (PaddleX !== 10'd480 || BallEnable !== 1'b0 || BallServe !== 1'b1) begin bad++; $display("FAIL midserve_reset_ball: got x=%0d en=%b serve=%b want 480 0 1", PaddleX, BallEnable, BallServe); end
      total++; if (Score !== 8'd0 || Lives !== 2'd3 || GameOver !== 1'b0 || Win !== 1'b0) begin bad++; $display("FAIL midserve_reset_game: got score=%0d lives=%0d over=%b win=%b want 0 3 0 0", Score, Lives, GameOver, Win); end
      for (int i = 0; i < 70; i++) begin frame_tick(); step(1); end
      total++; if (BallEnable !== 1'b0 || BallServe !== 1'b1) begin bad++; $display("FAIL midserve_stays_idle: got en=%b serve=%b want 0 1", BallEnable, BallServe); end
   endtask

   initial begin
      test_reset();
      test_serve();
      test_brick_sticky();
      test_paddle();
      test_lives();
      test_win();
      test_reset_mid_serve();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/breakout_game_ctrl.md
BREAKOUT_GAME_CTRL -- requirements
Module: breakout_game_ctrl

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- PADDLE_INIT, 10'd480: paddle X after reset/serve.
- PADDLE_MIN, 10'd16: lowest PaddleX.
- PADDLE_MAX, 10'd944: highest PaddleX.
- PADDLE_STEP, 4: pixels moved per frame.
- START_LIVES, 3: lives at game start.
- SERVE_FRAMES, 60: frames held in SERVE.
- TOTAL_BRICKS, 8'd32: score that wins the game.
REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- clk, in, 1: single system clock.
- reset, in, 1: synchronous, active-high reset.
- FrameTick, in, 1: one-cycle pulse per video frame, at vSync start.
- StartBtn, in, 1: start button, synchronous level.
- LeftBtn, in, 1: move-left button, synchronous level.
- RightBtn, in, 1: move-right button, synchronous level.
- Collision, in, 1: videogen ball-collision level; may be high for many clocks.
- BrickHit, in, 1: videogen brick-hit level; may be high for many clocks.
- BallLost, in, 1: ball passed below the paddle; level.
- PaddleX, out, 10: paddle position to the videogen.
- BallEnable, out, 1: ball motion allowed.
- BallServe, out, 1: videogen holds the ball at its serve position.
- Score, out, 8: bricks destroyed this game.
- Lives, out, 2: remaining lives.
- GameOver, out, 1: game ended.
- Win, out, 1: game ended by clearing all bricks.

Function
REQ-003 The FSM SHALL have the states IDLE, SERVE, PLAY, LOST and OVER.
REQ-004 IDLE: BallEnable=0, BallServe=1, PaddleX=PADDLE_INIT; a StartBtn rising edge SHALL load Score=0, Lives=START_LIVES and enter SERVE on the next clock.
REQ-005 StartBtn edge detection SHALL use one internal register, so a held button yields exactly one start.
REQ-006 SERVE: BallServe=1, BallEnable=0, PaddleX=PADDLE_INIT on entry.
- The frame counter SHALL load SERVE_FRAMES on entry and decrement on each FrameTick.
- The FSM SHALL enter PLAY on the clock after the FrameTick that brings the counter to 0.
REQ-007 PLAY: BallEnable=1, BallServe=0.
REQ-008 PLAY SHALL latch BrickHit into a sticky per-frame flag; on FrameTick the flag SHALL add exactly 1 to Score and then clear, so one frame scores at most 1.
REQ-009 PLAY SHALL latch BallLost into a sticky flag; on FrameTick with that flag set, the FSM SHALL enter LOST.
REQ-010 When a BrickHit and a BallLost fall in the same frame, the score increment SHALL apply before the LOST transition.
REQ-011 If the updated Score equals TOTAL_BRICKS, the FSM SHALL enter OVER with Win=1; this takes priority over LOST.
REQ-012 LOST SHALL last exactly one clock and decrement Lives.
- If the new Lives is 0, the FSM SHALL enter OVER with Win=0.
- Otherwise it SHALL enter SERVE.
REQ-013 OVER: GameOver=1, BallEnable=0, BallServe=1; Score, Lives and Win SHALL hold.
- A StartBtn rising edge SHALL behave as in IDLE: reload, clear Win and GameOver, enter SERVE.
REQ-014 The paddle SHALL move only in SERVE and PLAY, and only on FrameTick.
- LeftBtn alone: PaddleX -= PADDLE_STEP, saturating at PADDLE_MIN.
- RightBtn alone: PaddleX += PADDLE_STEP, saturating at PADDLE_MAX.
- Both or neither: no change.
- Arithmetic SHALL use 11-bit intermediates; PaddleX SHALL never wrap.
REQ-015 Score SHALL saturate at 8'hFF.
REQ-016 Collision SHALL not affect state; it is accepted for interface completeness only.
REQ-017 All outputs SHALL be registered; state-driven outputs change on the clock after the transition.

Reset
REQ-018 On reset=1 at a clk edge, the block SHALL go to IDLE with: PaddleX=PADDLE_INIT, BallEnable=0, BallServe=1, Score=0, Lives=START_LIVES, GameOver=0, Win=0, all sticky flags, counters and the edge register cleared.
REQ-019 Reset SHALL take precedence over every other input in every state, including mid-SERVE countdown and within LOST.

Structure
REQ-020 State encoding and the defaults for PADDLE_INIT, PADDLE_MIN, PADDLE_MAX, START_LIVES, SERVE_FRAMES and TOTAL_BRICKS SHALL live in a shared package, breakout_pkg.
REQ-021 Paddle motion and saturation SHALL be a sub-module, breakout_paddle_ctrl (clk, reset, FrameTick, enable, LeftBtn, RightBtn, load, PaddleX).

Verification
REQ-022 Reset, then StartBtn pulse -> SERVE; BallServe=1; PLAY entered after the 60th FrameTick; BallEnable=1 on the next clock.
REQ-023 In PLAY, BrickHit high for 200 clocks within one frame -> Score rises from 0 to 1 only, at FrameTick.
REQ-024 LeftBtn held for 200 frames from PaddleX=480 -> PaddleX reaches 16 and stays there; RightBtn held -> stops at 944; both held -> unchanged.
REQ-025 BallLost in three separate frames with Lives=3 -> Lives 2, 1, 0; GameOver=1 and Win=0 after the third; StartBtn -> Lives=3, Score=0, SERVE.
REQ-026 With Score=31, BrickHit and BallLost in the same frame -> Score=32, OVER, Win=1, Lives unchanged.
REQ-027 Reset asserted mid-SERVE countdown at frame 30 -> IDLE with all outputs at their REQ-018 values on the next clock.
